// File: rtl/ase_hssi_pkt_monitor.sv
// ase_hssi_pkt_monitor: passive AXI-Stream tap that builds one summary record per packet
// and queues it in a small FIFO for the HSSI event logger.
module ase_hssi_pkt_monitor #(
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16,
   parameter int TS_W       = 32,
   parameter int CHANNEL_ID = 0
) (
   input  logic                    clk,
   input  logic                    SoftReset_n,
   input  logic                    mon_tvalid,
   input  logic                    mon_tready,
   input  logic                    mon_tlast,
   input  logic [DATA_WIDTH/8-1:0] mon_tkeep,
   input  logic                    mon_tuser_err,
   output logic                    rec_valid,
   input  logic                    rec_ready,
   output logic [7:0]              rec_chan,
   output logic [TS_W-1:0]         rec_start_ts,
   output logic [TS_W-1:0]         rec_end_ts,
   output logic [CNT_W-1:0]        rec_bytes,
   output logic [CNT_W-1:0]        rec_beats,
   output logic [2:0]              rec_err,
   output logic [15:0]             drop_cnt,
   output logic                    ovf_sticky,
   output logic                    proto_sticky
);
   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int KC_W   = $clog2(KEEP_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   typedef enum logic {IDLE, IN_PKT} state_t;
   typedef struct packed {
      logic [TS_W-1:0]  start_ts;
      logic [TS_W-1:0]  end_ts;
      logic [CNT_W-1:0] bytes;
      logic [CNT_W-1:0] beats;
      logic [2:0]       err;
   } rec_t;
   state_t           state, state_nx;
   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  acc_start;
   logic [CNT_W-1:0] acc_bytes, acc_beats;
   logic [2:0]       acc_err;
   rec_t             rec_nx, stage;
   logic             stage_v;
   rec_t             mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count;
   logic             accept, first, hole, prev_stall, pop, full, push_ok;
   logic [KC_W-1:0]  keep_cnt;
   logic [CNT_W:0]   beats_sum, bytes_sum;
   assign accept = mon_tvalid && mon_tready;
   assign hole   = (mon_tkeep == '0) || ((mon_tkeep & (mon_tkeep + KEEP_W'(1))) != '0);
   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < KEEP_W; i++) keep_cnt = keep_cnt + KC_W'(mon_tkeep[i]);
   end
   always_ff @(posedge clk or negedge SoftReset_n)
      if (!SoftReset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (accept) state_nx = mon_tlast ? IDLE : IN_PKT;
   end
   // Record as it stands after the current beat; the first beat starts from zero.
   always_comb begin
      first           = state == IDLE;
      beats_sum       = {1'b0, first ? '0 : acc_beats} + (CNT_W+1)'(1);
      bytes_sum       = {1'b0, first ? '0 : acc_bytes} + (CNT_W+1)'(keep_cnt);
      rec_nx.start_ts = first ? ts : acc_start;
      rec_nx.end_ts   = ts;
      rec_nx.beats    = beats_sum[CNT_W] ? CNT_MAX : beats_sum[CNT_W-1:0];
      rec_nx.bytes    = bytes_sum[CNT_W] ? CNT_MAX : bytes_sum[CNT_W-1:0];
      rec_nx.err      = (first ? 3'b000 : acc_err) |
                        {hole, beats_sum[CNT_W] | bytes_sum[CNT_W], mon_tuser_err};
   end
   always_ff @(posedge clk or negedge SoftReset_n)
      if (!SoftReset_n) begin
         ts           <= '0;
         acc_start    <= '0;
         acc_bytes    <= '0;
         acc_beats    <= '0;
         acc_err      <= '0;
         stage        <= '0;
         stage_v      <= 1'b0;
         prev_stall   <= 1'b0;
         proto_sticky <= 1'b0;
      end else begin
         ts      <= ts + TS_W'(1);
         stage_v <= accept && mon_tlast;
         if (accept) begin
            acc_start <= rec_nx.start_ts;
            acc_bytes <= rec_nx.bytes;
            acc_beats <= rec_nx.beats;
            acc_err   <= rec_nx.err;
         end
         if (accept && mon_tlast) stage <= rec_nx;
         prev_stall <= mon_tvalid && !mon_tready;
         if (prev_stall && !mon_tvalid) proto_sticky <= 1'b1;
      end
   assign rec_valid = count != '0;
   assign full      = count == (PW+1)'(FIFO_DEPTH);
   assign pop       = rec_valid && rec_ready;
   assign push_ok   = stage_v && (!full || pop);
   always_ff @(posedge clk or negedge SoftReset_n)
      if (!SoftReset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         drop_cnt   <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= stage;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
         if (stage_v && !push_ok) begin
            ovf_sticky <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   assign {rec_start_ts, rec_end_ts, rec_bytes, rec_beats, rec_err} = mem[rd_ptr];
   assign rec_chan = rec_valid ? 8'(CHANNEL_ID) : 8'd0;
endmodule
